regfile_mp: RTL and testbench

//  Parametrised multi-read-port integer register file for the RV32 core datapath; successor to the fixed 2R1W regfile.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_clear_seq.sv | 47 ++++
 rtl/regfile_mp.sv | 103 ++++++++++
 tb/tb_regfile_mp.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, state encoding and address-width helper for the
// multi-read-port register file.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } rf_state_t;

   // Never return less than one address bit, so NREGS=2 still gets an index.
   function automatic int rf_aw(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Reset sequencer: walks clr_idx from 1 to NREGS-1 writing zeros, then
// raises ready. Re-entering reset restarts the walk from index 1.
module regfile_clear_seq
   import regfile_pkg::*;
#(
   parameter int NREGS = NREGS_DEF,
   parameter int AW    = rf_aw(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          ready,
   output logic          clr_we,
   output logic [AW-1:0] clr_idx
);

   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   rf_state_t     state_q, state_d;
   logic [AW-1:0] idx_q;
   logic          last;

   assign last    = (idx_q == LAST);
   assign clr_idx = idx_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CLEAR;
         idx_q   <= AW'(1);
      end else begin
         state_q <= state_d;
         if (state_q == CLEAR && !last)
            idx_q <= idx_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == CLEAR && last)
         state_d = RUN;
   end

   always_comb begin
      ready  = (state_q == RUN);
      clr_we = (state_q == CLEAR);
   end

endmodule

// File: rtl/regfile_mp.sv
// NRD-read / 1-write integer register file with x0 hardwired to zero,
// same-cycle write bypass and a clear sweep after reset.
// Optional busy scoreboard: define REGFILE_SCOREBOARD_EN.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int NREGS   = NREGS_DEF,
   parameter int AW      = rf_aw(NREGS),
   parameter int NRD     = 2,
   parameter int DBG_REG = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 ready,
   input  logic                 wr_en,
   input  logic [AW-1:0]        wr_addr,
   input  logic [XLEN-1:0]      wr_data,
   input  logic [NRD*AW-1:0]    rd_addr,
   output logic [NRD*XLEN-1:0]  rd_data,
   output logic [XLEN-1:0]      dbg_data
`ifdef REGFILE_SCOREBOARD_EN
  ,input  logic                 claim_en,
   input  logic [AW-1:0]        claim_addr,
   output logic [NRD-1:0]       rd_busy
`endif
);

   localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (a != '0) && ({1'b0, a} < NREGS_W);
   endfunction

   logic            clr_we;
   logic [AW-1:0]   clr_idx;
   logic            wr_req;
   logic [XLEN-1:0] mem [NREGS];

   regfile_clear_seq #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_clear_seq (
      .clk     (clk),
      .rst     (rst),
      .ready   (ready),
      .clr_we  (clr_we),
      .clr_idx (clr_idx)
   );

   assign wr_req = ready && wr_en && addr_ok(wr_addr);

   // Storage has no reset: the sweep zeroes it. rst suppresses any pending write.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clr_we)
            mem[clr_idx] <= '0;
         else if (wr_req)
            mem[wr_addr] <= wr_data;
      end
   end

`ifdef REGFILE_SCOREBOARD_EN
   logic [NREGS-1:0] busy;
   logic             claim_req;

   assign claim_req = ready && claim_en && addr_ok(claim_addr);

   // Claim is applied after the write clear so a new producer keeps the bit set.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         if (wr_req)
            busy[wr_addr] <= 1'b0;
         if (claim_req)
            busy[claim_addr] <= 1'b1;
      end
   end
`endif

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] a;
      logic          ok;
      logic          hit;

      assign a   = rd_addr[i*AW +: AW];
      assign ok  = ready && addr_ok(a);
      assign hit = wr_req && (wr_addr == a);

      assign rd_data[i*XLEN +: XLEN] = !ok ? '0 : (hit ? wr_data : mem[a]);
`ifdef REGFILE_SCOREBOARD_EN
      assign rd_busy[i] = ok && busy[a] && !hit;
`endif
   end

   if (DBG_REG > 0 && DBG_REG < NREGS) begin : g_dbg
      assign dbg_data = ready ? mem[AW'(DBG_REG)] : '0;
   end else begin : g_dbg_zero
      assign dbg_data = '0;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default 32-entry instance plus a 24-entry instance
// for out-of-range addresses. Scoreboard checks need REGFILE_SCOREBOARD_EN.
module tb_regfile_mp;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] val;
   } exp_t;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  r0;
      logic [4:0]  r1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [31:0] edbg;
   } vec_t;

   localparam int K_READY = 0, K_RD0 = 1, K_RD1 = 2, K_DBG = 3, K_RD24 = 4,
                  K_BUSY0 = 5, K_BUSY1 = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        ready, wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data, dbg_data;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;

   logic        ready24, we24;
   logic [4:0]  wa24, ra24;
   logic [31:0] wd24, rdd24, dbg24;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];
   vec_t tbl[12];

   always #5 clk = ~clk;

`ifdef REGFILE_SCOREBOARD_EN
   logic       claim_en;
   logic [4:0] claim_addr;
   logic [1:0] rd_busy;
   logic       busy24;
`endif

   regfile_mp u_dut (
      .clk        (clk),
      .rst        (rst),
      .ready      (ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .dbg_data   (dbg_data)
`ifdef REGFILE_SCOREBOARD_EN
     ,.claim_en   (claim_en),
      .claim_addr (claim_addr),
      .rd_busy    (rd_busy)
`endif
   );

   regfile_mp #(.NREGS(24), .NRD(1)) u_dut24 (
      .clk        (clk),
      .rst        (rst),
      .ready      (ready24),
      .wr_en      (we24),
      .wr_addr    (wa24),
      .wr_data    (wd24),
      .rd_addr    (ra24),
      .rd_data    (rdd24),
      .dbg_data   (dbg24)
`ifdef REGFILE_SCOREBOARD_EN
     ,.claim_en   (1'b0),
      .claim_addr (5'd0),
      .rd_busy    (busy24)
`endif
   );

   task automatic push(input string n, input int k, input logic [31:0] v);
      exp_t e;
      e.name = n; e.kind = k; e.val = v;
      q.push_back(e);
   endtask

   task automatic compare_all();
      exp_t        e;
      logic [31:0] act;
      while (q.size() > 0) begin
         e = q.pop_front();
         act = '0;
         case (e.kind)
            K_READY: act = {31'd0, ready};
            K_RD0:   act = rd_data[31:0];
            K_RD1:   act = rd_data[63:32];
            K_DBG:   act = dbg_data;
            K_RD24:  act = rdd24;
`ifdef REGFILE_SCOREBOARD_EN
            K_BUSY0: act = {31'd0, rd_busy[0]};
            K_BUSY1: act = {31'd0, rd_busy[1]};
`endif
            default: act = 'x;
         endcase
         checks++;
         if (act !== e.val) begin
            errors++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
         end
      end
   endtask

   // Drive just after the active edge, compare mid-cycle.
   task automatic cyc_begin();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc_end();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle();
      wr_en = 1'b0; we24 = 1'b0;
`ifdef REGFILE_SCOREBOARD_EN
      claim_en = 1'b0;
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; idle(); wr_addr = '0; wr_data = '0; rd_addr = '0;
      wa24 = '0; wd24 = '0; ra24 = '0;
`ifdef REGFILE_SCOREBOARD_EN
      claim_addr = '0;
`endif
      tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        32'h0};
      tbl[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        32'h0};
      tbl[2]  = '{1'b1, 5'd6,  32'h11111111, 5'd6,  5'd6,  32'h11111111, 32'h11111111, 32'h0};
      tbl[3]  = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd6,  32'h0,        32'h11111111, 32'h0};
      tbl[4]  = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0};
      tbl[5]  = '{1'b1, 5'd15, 32'hA5A5A5A5, 5'd15, 5'd1,  32'hA5A5A5A5, 32'h0,        32'h0};
      tbl[6]  = '{1'b0, 5'd0,  32'h0,        5'd15, 5'd15, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
      tbl[7]  = '{1'b1, 5'd15, 32'h0F0F0F0F, 5'd15, 5'd5,  32'h0F0F0F0F, 32'hDEADBEEF, 32'hA5A5A5A5};
      tbl[8]  = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd15, 32'h0,        32'h0F0F0F0F, 32'h0F0F0F0F};
      tbl[9]  = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0,        32'h0F0F0F0F};
      tbl[10] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd6,  32'hFFFFFFFF, 32'h11111111, 32'h0F0F0F0F};
      tbl[11] = '{1'b1, 5'd5,  32'h00000001, 5'd6,  5'd5,  32'h11111111, 32'h00000001, 32'h0F0F0F0F};

      // Reset and first sweep; writes during the sweep must be ignored
      cyc_begin(); rst = 1'b1; cyc_end();
      for (int i = 0; i < 31; i++) begin
         cyc_begin();
         rst = 1'b0; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFE0000;
         rd_addr = {5'd15, 5'd3};
         push("ready_low_sweep", K_READY, 32'd0);
         push("rd_zero_sweep", K_RD0, 32'd0);
         push("dbg_zero_sweep", K_DBG, 32'd0);
         cyc_end();
      end
      cyc_begin(); idle(); push("ready_high", K_READY, 32'd1); cyc_end();
      for (int a = 1; a < 32; a++) begin
         cyc_begin();
         rd_addr = {5'(32 - a), 5'(a)};
         push("cleared_rd0", K_RD0, 32'd0);
         push("cleared_rd1", K_RD1, 32'd0);
         cyc_end();
      end

      // Table-driven write/read/bypass/x0/dbg vectors
      foreach (tbl[i]) begin
         cyc_begin();
         wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
         rd_addr = {tbl[i].r1, tbl[i].r0};
         push($sformatf("vec%0d_rd0", i), K_RD0, tbl[i].e0);
         push($sformatf("vec%0d_rd1", i), K_RD1, tbl[i].e1);
         push($sformatf("vec%0d_dbg", i), K_DBG, tbl[i].edbg);
         cyc_end();
      end
      cyc_begin(); idle(); cyc_end();

      // 24-entry instance: out-of-range write ignored, top register usable
      cyc_begin(); we24 = 1'b1; wa24 = 5'd30; wd24 = 32'h12345678; ra24 = 5'd30;
      push("oor_bypass", K_RD24, 32'd0); cyc_end();
      cyc_begin(); we24 = 1'b0; push("oor_stored", K_RD24, 32'd0); cyc_end();
      cyc_begin(); we24 = 1'b1; wa24 = 5'd23; wd24 = 32'h55; ra24 = 5'd23;
      push("top24_bypass", K_RD24, 32'h55); cyc_end();
      cyc_begin(); we24 = 1'b0; push("top24_stored", K_RD24, 32'h55); cyc_end();
      cyc_begin(); ra24 = 5'd24; push("oor_read24", K_RD24, 32'd0); cyc_end();

      // Write x7, reset, then reset again at sweep cycle 10
      cyc_begin(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'd1; rd_addr = {5'd8, 5'd7};
      push("x7_bypass", K_RD0, 32'd1); cyc_end();
      cyc_begin(); idle(); push("x7_stored", K_RD0, 32'd1); cyc_end();
`ifdef REGFILE_SCOREBOARD_EN
      cyc_begin(); claim_en = 1'b1; claim_addr = 5'd9; cyc_end();
`endif
      cyc_begin(); idle(); rst = 1'b1; cyc_end();
      for (int i = 0; i < 11; i++) begin
         cyc_begin(); rst = (i == 10);
         push("ready_low_pre", K_READY, 32'd0); cyc_end();
      end
      for (int i = 0; i < 31; i++) begin
         cyc_begin(); rst = 1'b0;
         wr_en = (i == 20); wr_addr = 5'd8; wr_data = 32'd77;
         push("ready_low_restart", K_READY, 32'd0);
         push("x7_zero_restart", K_RD0, 32'd0);
`ifdef REGFILE_SCOREBOARD_EN
         rd_addr = {5'd8, 5'd9};
         push("busy_zero_sweep", K_BUSY0, 32'd0);
`endif
         cyc_end();
      end
      cyc_begin(); idle(); rd_addr = {5'd8, 5'd7};
      push("ready_high_restart", K_READY, 32'd1);
      push("x7_cleared", K_RD0, 32'd0);
      push("x8_write_ignored", K_RD1, 32'd0);
      push("dbg_cleared", K_DBG, 32'd0);
      cyc_end();

`ifdef REGFILE_SCOREBOARD_EN
      cyc_begin(); rd_addr = {5'd10, 5'd9};
      push("busy_cleared_by_rst", K_BUSY0, 32'd0); cyc_end();
      cyc_begin(); claim_en = 1'b1; claim_addr = 5'd9; rd_addr = {5'd10, 5'd9};
      push("busy_not_yet", K_BUSY0, 32'd0); push("busy_other", K_BUSY1, 32'd0); cyc_end();
      cyc_begin(); idle(); rd_addr = {5'd9, 5'd9};
      push("busy_set0", K_BUSY0, 32'd1); push("busy_set1", K_BUSY1, 32'd1); cyc_end();
      cyc_begin(); wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'd99; rd_addr = {5'd10, 5'd9};
      push("busy_bypass", K_BUSY0, 32'd0); push("busy_bypass_data", K_RD0, 32'd99); cyc_end();
      cyc_begin(); idle(); rd_addr = {5'd9, 5'd9};
      push("busy_released0", K_BUSY0, 32'd0); push("busy_released1", K_BUSY1, 32'd0); cyc_end();
      cyc_begin(); wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'd5;
      claim_en = 1'b1; claim_addr = 5'd9; rd_addr = {5'd0, 5'd9};
      push("busy_same_cycle", K_BUSY0, 32'd0); push("busy_x0", K_BUSY1, 32'd0); cyc_end();
      cyc_begin(); idle(); rd_addr = {5'd9, 5'd9};
      push("busy_new_producer0", K_BUSY0, 32'd1); push("busy_new_producer1", K_BUSY1, 32'd1); cyc_end();
      cyc_begin(); claim_en = 1'b1; claim_addr = 5'd0; rd_addr = {5'd0, 5'd0}; cyc_end();
      cyc_begin(); idle(); push("busy_x0_claim", K_BUSY0, 32'd0); cyc_end();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
